// File: rtl/i2s_transmitter_pkg.sv
// rtl/i2s_transmitter_pkg.sv - shared audio types and FSM state encoding for the I2S transmit path
package i2s_transmitter_pkg;

    localparam int DEFAULT_SAMPLE_WIDTH = 24;

    typedef logic [DEFAULT_SAMPLE_WIDTH-1:0] sample_t;

    // Left occupies the upper half of a packed pair, matching the stream layout.
    typedef struct packed {
        sample_t left;
        sample_t right;
    } stereo_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tx_state_t;

endpackage

// File: rtl/i2s_transmitter_if.sv
// rtl/i2s_transmitter_if.sv - stream handshake interface carrying stereo sample pairs
interface Axis_If
    import i2s_transmitter_pkg::*;
#(
    parameter int WIDTH = 2 * DEFAULT_SAMPLE_WIDTH
) ();

    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/i2s_transmitter_bclk_gen.sv
// rtl/i2s_transmitter_bclk_gen.sv - bit clock divider with one-cycle rise/fall strobes
module i2s_bclk_gen #(
    parameter int BCLK_HALF = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic bclk,
    output logic rise,
    output logic fall
);

    localparam int            DW      = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(BCLK_HALF - 1);

    logic [DW-1:0] div_cnt;
    logic          wrap;

    // Strobes mark the cycle whose closing edge toggles bclk, so callers update in lockstep.
    assign wrap = en && (div_cnt == DIV_MAX);
    assign rise = wrap && !bclk;
    assign fall = wrap && bclk;

    // Divider: held at zero with bclk low while disabled, toggles bclk on each wrap.
    always_ff @(posedge clk) begin
        if (reset || !en) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (wrap) begin
            div_cnt <= '0;
            bclk    <= !bclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2s_transmitter.sv
// rtl/i2s_transmitter.sv - I2S master serializer with one-pair reserve; I2S_TX_HOLD_LAST_EN repeats last pair on underrun
module i2s_transmitter
    import i2s_transmitter_pkg::*;
#(
    parameter int SAMPLE_WIDTH = DEFAULT_SAMPLE_WIDTH,
    parameter int SLOT_BITS    = 32,
    parameter int BCLK_HALF    = 16
) (
    input  logic  clk,
    input  logic  reset,
    Axis_If.slave din,
    output logic  bclk,
    output logic  lrclk,
    output logic  sdata,
    output logic  underrun
);

    localparam int            FRAME_BITS = 2 * SLOT_BITS;
    localparam int            BW         = $clog2(FRAME_BITS);
    localparam logic [BW-1:0] BIT_MAX    = BW'(FRAME_BITS - 1);

    tx_state_t               state_q, state_d;
    logic [SAMPLE_WIDTH-1:0] hold_l, hold_r;
    logic [SAMPLE_WIDTH-1:0] frame_l, frame_r;
    logic                    hold_full, hold_full_d;
    logic [BW-1:0]           bit_cnt, bit_nxt;
    logic                    bclk_rise, bclk_fall, unused_rise;
    logic                    xfer, frame_load;
    logic                    sdata_d, lrclk_d;
    int                      slot_k, slot_c;
    logic [SAMPLE_WIDTH-1:0] chan_word, shifted;

    i2s_bclk_gen #(.BCLK_HALF(BCLK_HALF)) u_bclk_gen (
        .clk   (clk),
        .reset (reset),
        .en    (state_q == RUN),
        .bclk  (bclk),
        .rise  (bclk_rise),
        .fall  (bclk_fall)
    );

    assign unused_rise = bclk_rise;
    assign xfer        = din.valid && din.ready;
    assign frame_load  = bclk_fall && (bit_cnt == BIT_MAX);
    assign bit_nxt     = (bit_cnt == BIT_MAX) ? '0 : bit_cnt + 1'b1;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next state: start running once the first pair is sitting in hold.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hold_full) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // Hold occupancy: a frame load drains it, a transfer fills it (never both, ready gates that).
    always_comb begin
        hold_full_d = hold_full;
        if (frame_load && hold_full) hold_full_d = 1'b0;
        if (xfer)                    hold_full_d = 1'b1;
    end

    // Serial bit for the slot position reached at the coming falling toggle.
    always_comb begin
        slot_k    = int'(bit_nxt) % SLOT_BITS;
        slot_c    = int'(bit_nxt) / SLOT_BITS;
        lrclk_d   = (slot_c != 0);
        chan_word = (slot_c != 0) ? frame_r : frame_l;
        shifted   = '0;
        sdata_d   = 1'b0;
        if (slot_k >= 1 && slot_k <= SAMPLE_WIDTH) begin
            shifted = chan_word << (slot_k - 1);
            sdata_d = shifted[SAMPLE_WIDTH-1];
        end
    end

    // Input side: hold register, its flag, and ready registered from the next flag value.
    always_ff @(posedge clk) begin
        if (reset) begin
            din.ready <= 1'b0;
            hold_full <= 1'b0;
            hold_l    <= '0;
            hold_r    <= '0;
        end else begin
            din.ready <= !hold_full_d;
            hold_full <= hold_full_d;
            if (xfer) {hold_l, hold_r} <= din.data;
        end
    end

    // Output side: bit counter, word select and serial data move only on bclk falls.
    always_ff @(posedge clk) begin
        if (reset || state_q == IDLE) begin
            bit_cnt <= BIT_MAX;
            lrclk   <= 1'b0;
            sdata   <= 1'b0;
        end else if (bclk_fall) begin
            bit_cnt <= bit_nxt;
            lrclk   <= lrclk_d;
            sdata   <= sdata_d;
        end
    end

    // Frame register loads at each frame start; an empty hold raises underrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_l  <= '0;
            frame_r  <= '0;
            underrun <= 1'b0;
        end else begin
            underrun <= frame_load && !hold_full;
            if (frame_load) begin
                if (hold_full) begin
                    frame_l <= hold_l;
                    frame_r <= hold_r;
                end
`ifdef I2S_TX_HOLD_LAST_EN
                else begin
                    frame_l <= frame_l;
                    frame_r <= frame_r;
                end
`else
                else begin
                    frame_l <= '0;
                    frame_r <= '0;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_i2s_transmitter.sv
// tb/tb_i2s_transmitter.sv - directed self-checking bench for i2s_transmitter
module tb_i2s_transmitter;

    logic clk = 1'b0;
    logic reset;
    logic bclk, lrclk, sdata, underrun;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    Axis_If #(.WIDTH(48)) din ();

    i2s_transmitter #(.SAMPLE_WIDTH(24), .SLOT_BITS(32), .BCLK_HALF(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .din      (din),
        .bclk     (bclk),
        .lrclk    (lrclk),
        .sdata    (sdata),
        .underrun (underrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Capture sdata/lrclk at every bclk rise and log underrun pulses.
    logic bclk_q = 1'b0;
    logic rs_sdata[$];
    logic rs_lr[$];
    int   ur_count = 0;
    int   ur_last_cyc = -1;
    always @(negedge clk) begin
        if (bclk && !bclk_q) begin
            rs_sdata.push_back(sdata);
            rs_lr.push_back(lrclk);
        end
        bclk_q = bclk;
        if (underrun) begin
            ur_count++;
            ur_last_cyc = cyc;
        end
    end

    localparam logic [63:0] EXP_LR = {32'h0, 32'hFFFF_FFFF};

    function automatic logic [63:0] exp_bits(input logic [23:0] l, input logic [23:0] r);
        return {1'b0, l, 7'b0, 1'b0, r, 7'b0};
    endfunction

    function automatic logic [63:0] cap_sdata(input int start);
        logic [63:0] v;
        for (int i = 0; i < 64; i++) v[63-i] = rs_sdata[start+i];
        return v;
    endfunction

    function automatic logic [63:0] cap_lr(input int start);
        logic [63:0] v;
        for (int i = 0; i < 64; i++) v[63-i] = rs_lr[start+i];
        return v;
    endfunction

    task automatic do_reset();
        din.valid = 1'b0;
        din.data  = '0;
        reset     = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_pair(input logic [47:0] d, output int acc, output bit ok);
        din.data  = d;
        din.valid = 1'b1;
        ok  = 1'b0;
        acc = -1;
        for (int n = 0; n < 2000 && !ok; n++) begin
            if (din.ready) begin
                @(negedge clk);
                acc = cyc;
                ok  = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        din.valid = 1'b0;
    endtask

    task automatic wait_rises(input int target, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 5000 && !ok; n++) begin
            @(posedge clk);
            if (rs_sdata.size() >= target) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        din.valid = 1'b0;
        din.data  = '0;
        repeat (10) @(negedge clk);
        checks++;
        if ({bclk, lrclk, sdata, din.ready, underrun} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=00000", {bclk, lrclk, sdata, din.ready, underrun});
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (din.ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset got=%b exp=1", din.ready);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if ({bclk, lrclk, sdata} !== 3'b0) begin
                failures++;
                $display("FAIL idle_outputs cycle=%0d got=%b exp=000", i, {bclk, lrclk, sdata});
            end
        end
    endtask

    task automatic test_single_frame();
        int          base, acc, lat, ur0;
        bit          ok;
        logic [63:0] exp2;
        do_reset();
        base = rs_sdata.size();
        ur0  = ur_count;
        send_pair({24'hA5A5A5, 24'h5A5A5A}, acc, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL single_accept got=timeout exp=accepted");
        end
        lat = -1;
        for (int n = 0; n < 40 && lat < 0; n++) begin
            @(negedge clk);
            if (sdata === 1'b1) lat = cyc - acc;
        end
        checks++;
        if (lat !== 9) begin
            failures++;
            $display("FAIL msb_latency got=%0d exp=9", lat);
        end
        wait_rises(base + 65, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL frame1_rises got=timeout exp=65 rises");
        end else begin
            checks++;
            if (cap_sdata(base + 1) !== exp_bits(24'hA5A5A5, 24'h5A5A5A)) begin
                failures++;
                $display("FAIL frame1_sdata got=%h exp=%h", cap_sdata(base + 1), exp_bits(24'hA5A5A5, 24'h5A5A5A));
            end
            checks++;
            if (cap_lr(base + 1) !== EXP_LR) begin
                failures++;
                $display("FAIL frame1_lrclk got=%h exp=%h", cap_lr(base + 1), EXP_LR);
            end
        end
`ifdef I2S_TX_HOLD_LAST_EN
        exp2 = exp_bits(24'hA5A5A5, 24'h5A5A5A);
`else
        exp2 = 64'h0;
`endif
        wait_rises(base + 129, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL frame2_rises got=timeout exp=129 rises");
        end else begin
            checks++;
            if (ur_count - ur0 < 1 || ur_last_cyc - acc < 261) begin
                failures++;
                $display("FAIL underrun_seen got=count %0d exp=at least 1", ur_count - ur0);
            end
            checks++;
            if (cap_sdata(base + 65) !== exp2) begin
                failures++;
                $display("FAIL frame2_sdata got=%h exp=%h", cap_sdata(base + 65), exp2);
            end
            checks++;
            if (cap_lr(base + 65) !== EXP_LR) begin
                failures++;
                $display("FAIL frame2_lrclk got=%h exp=%h", cap_lr(base + 65), EXP_LR);
            end
        end
    endtask

    task automatic test_underrun_timing();
        int base, acc, ur0, first_ur;
        bit ok;
        do_reset();
        base = rs_sdata.size();
        ur0  = ur_count;
        send_pair({24'hA5A5A5, 24'h5A5A5A}, acc, ok);
        wait_rises(base + 64, ok);
        checks++;
        if (ur_count !== ur0) begin
            failures++;
            $display("FAIL underrun_early got=%0d exp=0", ur_count - ur0);
        end
        first_ur = -1;
        for (int n = 0; n < 40 && first_ur < 0; n++) begin
            @(negedge clk);
            if (underrun === 1'b1) first_ur = cyc;
        end
        @(negedge clk);
        checks++;
        if (first_ur - acc !== 261) begin
            failures++;
            $display("FAIL underrun_cycle got=%0d exp=261", first_ur - acc);
        end
        checks++;
        if (ur_count - ur0 !== 1) begin
            failures++;
            $display("FAIL underrun_width got=%0d exp=1", ur_count - ur0);
        end
    endtask

    task automatic test_back_to_back();
        int          base, ur0;
        int          acc[5];
        bit          ok;
        logic [23:0] v;
        do_reset();
        base = rs_sdata.size();
        ur0  = ur_count;
        for (int k = 0; k < 5; k++) begin
            v = 24'(k + 1);
            send_pair({v, v}, acc[k], ok);
        end
        for (int k = 1; k < 4; k++) begin
            checks++;
            if (acc[k] - acc[0] !== 6 + 256 * (k - 1)) begin
                failures++;
                $display("FAIL b2b_accept%0d got=%0d exp=%0d", k + 1, acc[k] - acc[0], 6 + 256 * (k - 1));
            end
        end
        wait_rises(base + 193, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL b2b_rises got=timeout exp=193 rises");
        end else begin
            for (int k = 0; k < 3; k++) begin
                v = 24'(k + 1);
                checks++;
                if (cap_sdata(base + 1 + 64 * k) !== exp_bits(v, v)) begin
                    failures++;
                    $display("FAIL b2b_frame%0d got=%h exp=%h", k + 1, cap_sdata(base + 1 + 64 * k), exp_bits(v, v));
                end
            end
            checks++;
            if (ur_count !== ur0) begin
                failures++;
                $display("FAIL b2b_underrun got=%0d exp=0", ur_count - ur0);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int base, acc, acc2;
        bit ok;
        do_reset();
        base = rs_sdata.size();
        send_pair({24'hA5A5A5, 24'h5A5A5A}, acc, ok);
        send_pair({24'hFFFFFF, 24'hFFFFFF}, acc2, ok);
        wait_rises(base + 41, ok);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({bclk, lrclk, sdata, din.ready} !== 4'b0) begin
            failures++;
            $display("FAIL midreset_outputs got=%b exp=0000", {bclk, lrclk, sdata, din.ready});
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (din.ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_ready got=%b exp=1", din.ready);
        end
        base = rs_sdata.size();
        repeat (30) @(negedge clk);
        checks++;
        if (rs_sdata.size() !== base || bclk !== 1'b0) begin
            failures++;
            $display("FAIL midreset_idle got=%0d rises exp=0", rs_sdata.size() - base);
        end
        send_pair({24'h123456, 24'h654321}, acc, ok);
        wait_rises(base + 65, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL midreset_rises got=timeout exp=65 rises");
        end else begin
            checks++;
            if (cap_sdata(base + 1) !== exp_bits(24'h123456, 24'h654321)) begin
                failures++;
                $display("FAIL midreset_frame got=%h exp=%h", cap_sdata(base + 1), exp_bits(24'h123456, 24'h654321));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_underrun_timing();
        test_back_to_back();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
